core_loader: RTL and testbench
==============================

CORE_LOADER -- requirements
Module: core_loader

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_word  in  32  loader stream word.
- i_valid  in  1  i_word valid.
- o_ready  out  1  loader can accept a word; a transfer occurs on an edge where i_valid && o_ready.
- o_setup  out  1  holds s_core in setup mode while high.
- o_pc_start_addr  out  32  start PC for s_core.
- o_inst_mem_addr  out  32  instruction-memory write address.
- o_inst_mem_data  out  32  instruction-memory write data.
- o_inst_mem_we  out  1  one-cycle instruction write strobe.
- o_load_reg_addr  out  5  register-file write index.
- o_load_reg_data  out  32  register-file write data.
- o_load_reg_we  out  1  one-cycle register write strobe.
- o_error  out  1  one-cycle pulse on a protocol error.

Function
REQ-002 Header word: cmd = i_word[31:28]; count = i_word[15:0]; reg index = i_word[4:0].
REQ-003 Command codes: 0x1 IMEM, 0x2 REG, 0x3 RUN, 0x4 HALT.
REQ-004 FSM states: IDLE, IMEM_ADDR, IMEM_DATA, REG_DATA, RUN_ADDR, RUN_ARM, RUN.
REQ-005 IDLE, header IMEM: latch count into a 16-bit counter, then go to IMEM_ADDR.
REQ-006 IMEM_ADDR: the accepted word becomes the base address, with bits[1:0] forced to 0.
- count=0: go to IDLE, with no write.
- otherwise: go to IMEM_DATA.
REQ-007 IMEM_DATA, each accepted word:
- write to the current address.
- advance the address by 4, wrapping modulo 2^32.
- decrement the counter.
- after the count-th word, go to IDLE.
REQ-008 IDLE, header REG: latch the reg index, then go to REG_DATA.
REQ-009 REG_DATA: the accepted word is written to the latched index, then go to IDLE.
- index 0: o_load_reg_we SHALL stay 0; no error.
REQ-010 IDLE, header RUN: go to RUN_ADDR.
REQ-011 RUN_ADDR: the accepted word is registered into o_pc_start_addr, then go to RUN_ARM.
REQ-012 RUN_ARM lasts exactly one cycle with o_ready=0, then goes to RUN.
- o_setup SHALL fall on entry to RUN, one cycle after o_pc_start_addr is updated.
REQ-013 RUN: o_setup=0.
- header HALT: go to IDLE; o_setup returns to 1 the next cycle.
- any other header: pulse o_error; stay in RUN.
REQ-014 IDLE:
- HALT: ignored, no error.
- unknown cmd (0x0, 0x5-0xF): pulse o_error; stay in IDLE.
REQ-015 Write strobes and their addr/data outputs SHALL be registered: asserted for exactly one cycle, in the cycle after the accepting edge.
- The addr/data outputs hold their value until the next write.
REQ-016 o_ready SHALL be 1 in every state except RUN_ARM and reset.
- i_valid while o_ready=0 SHALL be ignored; the source holds the word.
REQ-017 i_valid low mid-packet SHALL stall the FSM without timeout; the counter and address are preserved.
REQ-018 o_error SHALL be a single-cycle pulse and SHALL not change state, except as stated above.

Reset
REQ-019 On rst_n low, asynchronously:
- state=IDLE; o_setup=1; o_ready=0.
- all addr/data outputs = 0, including o_pc_start_addr.
- o_inst_mem_we, o_load_reg_we, o_error = 0; counter=0.
REQ-020 o_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-021 Reset mid-packet SHALL discard the partial packet; writes already issued are not undone.

Structure
REQ-022 A shared package SHALL hold the command-code constants, the FSM state enumeration, and the 16-bit count width.
REQ-023 No sub-module; the counter, address register and FSM live in core_loader.

Verification
REQ-024 Load the andi program:
- stimulus: [0x10000001, 0x00000004, 0x00127413], then [0x20000004, 0x00000001], then [0x30000000, 0x00000004].
- response: imem write addr 4 data 0x00127413; reg 4 write 0x00000001; o_pc_start_addr=4; o_setup falls 1 cycle later.
- connected to s_core: x8=0x00000001 after the first executed instruction.
REQ-025 IMEM count 3 with base 0xFFFFFFF8: writes at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; then back to IDLE.
REQ-026 Header 0x70000000 in IDLE -> o_error one cycle; a following REG packet completes normally.
REQ-027 In RUN:
- REG header -> o_error and o_setup stays 0.
- HALT (0x40000000) -> o_setup=1 the next cycle.
REQ-028 Reset during IMEM_DATA (2 of 5 words sent) -> outputs at reset values; a new REG packet afterwards is accepted.
REQ-029 REG packet to index 0 -> no o_load_reg_we, no o_error.

Source files
------------

// File: rtl/core_loader_pkg.sv
// Shared definitions for the s_core loader.
// Holds the loader command codes, the loader FSM state encoding and the
// widths of the packet counter and stream word.
package core_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned RIDX_W = 5;

  // Header command codes carried in i_word[31:28]
  localparam logic [3:0] CMD_IMEM = 4'h1;
  localparam logic [3:0] CMD_REG  = 4'h2;
  localparam logic [3:0] CMD_RUN  = 4'h3;
  localparam logic [3:0] CMD_HALT = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IMEM_ADDR = 3'd1,
    ST_IMEM_DATA = 3'd2,
    ST_REG_DATA  = 3'd3,
    ST_RUN_ADDR  = 3'd4,
    ST_RUN_ARM   = 3'd5,
    ST_RUN       = 3'd6
  } state_e;

endpackage

// File: rtl/core_loader.sv
// Streaming loader for s_core: decodes header/payload packets from a
// valid/ready word stream and turns them into instruction-memory writes,
// register-file writes and a start-PC / setup-release handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_word, i_valid         loader stream word and its valid
//   o_ready                 word accepted on an edge where i_valid && o_ready
//   o_setup                 holds s_core in setup mode while high
//   o_pc_start_addr         start PC for s_core
//   o_inst_mem_addr/_data/_we  one-cycle instruction-memory write
//   o_load_reg_addr/_data/_we  one-cycle register-file write
//   o_error                 one-cycle protocol-error pulse
module core_loader
  import core_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   i_word,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_setup,
  output logic [WORD_W-1:0]   o_pc_start_addr,
  output logic [WORD_W-1:0]   o_inst_mem_addr,
  output logic [WORD_W-1:0]   o_inst_mem_data,
  output logic                o_inst_mem_we,
  output logic [RIDX_W-1:0]   o_load_reg_addr,
  output logic [WORD_W-1:0]   o_load_reg_data,
  output logic                o_load_reg_we,
  output logic                o_error
);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_W-1:0]   addr_q;
  logic [RIDX_W-1:0]   reg_idx_q;
  logic                ready_q;
  logic                setup_q;
  logic [WORD_W-1:0]   pc_q;
  logic [WORD_W-1:0]   imem_addr_q;
  logic [WORD_W-1:0]   imem_data_q;
  logic                imem_we_q;
  logic [RIDX_W-1:0]   reg_addr_q;
  logic [WORD_W-1:0]   reg_data_q;
  logic                reg_we_q;
  logic                error_q;

  logic                xfer;
  logic [3:0]          cmd;

  assign xfer = i_valid && ready_q;
  assign cmd  = i_word[31:28];

  // Loader FSM with registered strobes and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      reg_idx_q   <= '0;
      ready_q     <= 1'b0;
      setup_q     <= 1'b1;
      pc_q        <= '0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      imem_we_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      reg_we_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle; ready is only withdrawn for RUN_ARM
      imem_we_q <= 1'b0;
      reg_we_q  <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            case (cmd)
              CMD_IMEM: begin
                cnt_q   <= i_word[CNT_W-1:0];
                state_q <= ST_IMEM_ADDR;
              end
              CMD_REG: begin
                reg_idx_q <= i_word[RIDX_W-1:0];
                state_q   <= ST_REG_DATA;
              end
              CMD_RUN:  state_q <= ST_RUN_ADDR;
              CMD_HALT: state_q <= ST_IDLE;
              default:  error_q <= 1'b1;
            endcase
          end
        end

        ST_IMEM_ADDR: begin
          if (xfer) begin
            addr_q  <= {i_word[WORD_W-1:2], 2'b00};
            state_q <= (cnt_q == '0) ? ST_IDLE : ST_IMEM_DATA;
          end
        end

        ST_IMEM_DATA: begin
          if (xfer) begin
            imem_addr_q <= addr_q;
            imem_data_q <= i_word;
            imem_we_q   <= 1'b1;
            addr_q      <= addr_q + WORD_W'(4);
            cnt_q       <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_REG_DATA: begin
          if (xfer) begin
            // x0 is hardwired in s_core, so the write is silently dropped
            if (reg_idx_q != '0) begin
              reg_addr_q <= reg_idx_q;
              reg_data_q <= i_word;
              reg_we_q   <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end

        ST_RUN_ADDR: begin
          if (xfer) begin
            pc_q    <= i_word;
            ready_q <= 1'b0;
            state_q <= ST_RUN_ARM;
          end
        end

        // One dead cycle so the start PC is stable before setup drops
        ST_RUN_ARM: begin
          setup_q <= 1'b0;
          state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (xfer) begin
            if (cmd == CMD_HALT) begin
              setup_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              error_q <= 1'b1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready         = ready_q;
  assign o_setup         = setup_q;
  assign o_pc_start_addr = pc_q;
  assign o_inst_mem_addr = imem_addr_q;
  assign o_inst_mem_data = imem_data_q;
  assign o_inst_mem_we   = imem_we_q;
  assign o_load_reg_addr = reg_addr_q;
  assign o_load_reg_data = reg_data_q;
  assign o_load_reg_we   = reg_we_q;
  assign o_error         = error_q;

endmodule

// File: tb/tb_core_loader.sv
// Self-checking bench for core_loader: table-driven header/REG vectors,
// hand-written multi-cycle sequences and randomized packet streams
// checked against a packet-level expectation model.
module tb_core_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_word = '0;
  logic        i_valid = 1'b0;
  logic        o_ready, o_setup;
  logic [31:0] o_pc_start_addr, o_inst_mem_addr, o_inst_mem_data, o_load_reg_data;
  logic        o_inst_mem_we, o_load_reg_we, o_error;
  logic [4:0]  o_load_reg_addr;

  core_loader dut (
    .clk(clk), .rst_n(rst_n), .i_word(i_word), .i_valid(i_valid),
    .o_ready(o_ready), .o_setup(o_setup), .o_pc_start_addr(o_pc_start_addr),
    .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data),
    .o_inst_mem_we(o_inst_mem_we), .o_load_reg_addr(o_load_reg_addr),
    .o_load_reg_data(o_load_reg_data), .o_load_reg_we(o_load_reg_we),
    .o_error(o_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit gaps_en = 1'b0;

  logic [63:0] exp_imem[$], act_imem[$], exp_reg[$], act_reg[$];
  int exp_err = 0, act_err = 0;

  // Observed write/error events, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_inst_mem_we) act_imem.push_back({o_inst_mem_addr, o_inst_mem_data});
      if (o_load_reg_we) act_reg.push_back({27'd0, o_load_reg_addr, o_load_reg_data});
      if (o_error) act_err++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send_word(input logic [31:0] w);
    int n;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        i_word = $urandom;
        @(negedge clk);
      end
    end
    i_word = w;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got o_ready=0 for 50 cycles expected 1");
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_imem_n"}, 64'(act_imem.size()), 64'(exp_imem.size()));
    for (int i = 0; i < exp_imem.size() && i < act_imem.size(); i++)
      chk({tag, "_imem"}, act_imem[i], exp_imem[i]);
    chk({tag, "_reg_n"}, 64'(act_reg.size()), 64'(exp_reg.size()));
    for (int i = 0; i < exp_reg.size() && i < act_reg.size(); i++)
      chk({tag, "_reg"}, act_reg[i], exp_reg[i]);
    chk({tag, "_err_n"}, 64'(act_err), 64'(exp_err));
    exp_imem.delete(); act_imem.delete();
    exp_reg.delete(); act_reg.delete();
    exp_err = 0; act_err = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(o_ready), 64'd0);
    chk({tag, "_setup"}, 64'(o_setup), 64'd1);
    chk({tag, "_pc"}, 64'(o_pc_start_addr), 64'd0);
    chk({tag, "_imem_ad"}, {o_inst_mem_addr, o_inst_mem_data}, 64'd0);
    chk({tag, "_reg_ad"}, {27'd0, o_load_reg_addr, o_load_reg_data}, 64'd0);
    chk({tag, "_strobes"}, 64'({o_inst_mem_we, o_load_reg_we, o_error}), 64'd0);
  endtask

  typedef struct {
    logic [31:0] w0;
    bit          two;
    logic [31:0] w1;
    int          exp_err;
    int          exp_regw;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, d, hdr, pc;
    int cnt, kind, c;
    logic [4:0] idx;

    vecs[0] = '{32'h0000_0000, 1'b0, 32'h0, 1, 0};
    vecs[1] = '{32'h5000_0000, 1'b0, 32'h0, 1, 0};
    vecs[2] = '{32'hF000_1234, 1'b0, 32'h0, 1, 0};
    vecs[3] = '{32'h4000_0000, 1'b0, 32'h0, 0, 0};
    vecs[4] = '{32'h2000_0007, 1'b1, 32'hDEAD_BEEF, 0, 1};
    vecs[5] = '{32'h2000_0000, 1'b1, 32'h1234_5678, 0, 0};
    vecs[6] = '{32'h2000_001F, 1'b1, 32'hA5A5_A5A5, 0, 1};
    vecs[7] = '{32'h7000_0000, 1'b0, 32'h0, 1, 0};
    vecs[8] = '{32'h2000_0003, 1'b1, 32'h0BAD_F00D, 0, 1};

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(o_ready), 64'd1);

    // Table-driven header / REG vectors
    foreach (vecs[i]) begin
      send_word(vecs[i].w0);
      if (vecs[i].two) send_word(vecs[i].w1);
      repeat (2) @(negedge clk);
      exp_err = vecs[i].exp_err;
      if (vecs[i].exp_regw != 0)
        exp_reg.push_back({27'd0, vecs[i].w0[4:0], vecs[i].w1});
      check_sb($sformatf("vec%0d", i));
    end

    // andi program load and run handshake
    send_word(32'h1000_0001);
    send_word(32'h0000_0004);
    send_word(32'h0012_7413);
    chk("andi_imem_we", 64'(o_inst_mem_we), 64'd1);
    chk("andi_imem_ad", {o_inst_mem_addr, o_inst_mem_data}, {32'h4, 32'h0012_7413});
    @(negedge clk);
    chk("andi_imem_we_1cyc", 64'(o_inst_mem_we), 64'd0);
    send_word(32'h2000_0004);
    send_word(32'h0000_0001);
    chk("andi_reg_we", 64'(o_load_reg_we), 64'd1);
    send_word(32'h3000_0000);
    send_word(32'h0000_0004);
    chk("andi_pc", 64'(o_pc_start_addr), 64'd4);
    chk("andi_setup_arm", 64'(o_setup), 64'd1);
    chk("andi_ready_arm", 64'(o_ready), 64'd0);
    @(negedge clk);
    chk("andi_setup_run", 64'(o_setup), 64'd0);
    chk("andi_ready_run", 64'(o_ready), 64'd1);
    // REG header while running is an error and setup stays low
    send_word(32'h2000_0004);
    chk("run_reg_err", 64'(o_error), 64'd1);
    @(negedge clk);
    chk("run_err_1cyc", 64'(o_error), 64'd0);
    chk("run_setup_low", 64'(o_setup), 64'd0);
    send_word(32'h4000_0000);
    chk("halt_setup", 64'(o_setup), 64'd1);
    exp_imem.push_back({32'h4, 32'h0012_7413});
    exp_reg.push_back({27'd0, 5'd4, 32'h1});
    exp_err = 1;
    check_sb("andi");

    // Address wrap at the top of the address space
    send_word(32'h1000_0003);
    send_word(32'hFFFF_FFFB);
    for (int i = 0; i < 3; i++) begin
      send_word(32'hC0DE_0000 + 32'(i));
      exp_imem.push_back({32'hFFFF_FFF8 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)});
    end
    send_word(32'h2000_0005);
    send_word(32'h0000_0055);
    exp_reg.push_back({27'd0, 5'd5, 32'h55});
    @(negedge clk);
    check_sb("wrap");

    // Reset in the middle of an IMEM payload
    send_word(32'h1000_0005);
    send_word(32'h0000_0100);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    exp_imem.push_back({32'h100, 32'h1111_1111});
    exp_imem.push_back({32'h104, 32'h2222_2222});
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    send_word(32'h2000_0009);
    send_word(32'h9999_9999);
    exp_reg.push_back({27'd0, 5'd9, 32'h9999_9999});
    @(negedge clk);
    check_sb("midrst");

    // Randomized packet streams with random valid gaps
    gaps_en = 1'b1;
    for (int round = 0; round < 4; round++) begin
      for (int p = 0; p < 25; p++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: begin
            cnt = $urandom_range(0, 4);
            base = $urandom;
            send_word({4'h1, 12'($urandom), 16'(cnt)});
            send_word(base);
            for (int i = 0; i < cnt; i++) begin
              d = $urandom;
              send_word(d);
              exp_imem.push_back({(base & 32'hFFFF_FFFC) + 32'(4 * i), d});
            end
          end
          1: begin
            idx = 5'($urandom_range(0, 31));
            d = $urandom;
            send_word({4'h2, 23'($urandom), idx});
            send_word(d);
            if (idx != 5'd0) exp_reg.push_back({27'd0, idx, d});
          end
          2: begin
            c = $urandom_range(5, 16);
            hdr = {4'(c), 28'($urandom)};
            send_word(hdr);
            exp_err++;
          end
          default: send_word({4'h4, 28'($urandom)});
        endcase
      end
      pc = $urandom;
      send_word({4'h3, 28'($urandom)});
      send_word(pc);
      chk("rnd_pc", 64'(o_pc_start_addr), 64'(pc));
      repeat ($urandom_range(1, 3)) begin
        c = $urandom_range(0, 14);
        if (c >= 4) c++;
        send_word({4'(c), 28'($urandom)});
        exp_err++;
      end
      chk("rnd_run_setup", 64'(o_setup), 64'd0);
      send_word({4'h4, 28'($urandom)});
      chk("rnd_halt_setup", 64'(o_setup), 64'd1);
      repeat (2) @(negedge clk);
      check_sb($sformatf("rnd%0d", round));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
